// File: rtl/audio_pll_lock_ctrl_if.sv
// Audio PLL lock controller bundle: PLL lock status and control requests in,
// PLL reset, audio reset, status flags, retry count and state out.
interface audio_pll_lock_ctrl_if;
  logic       pll_locked;
  logic       restart;
  logic       clr_status;
  logic       pll_rst;
  logic       audio_rst_n;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [3:0] retry_count;
  logic [2:0] state_o;

  modport master (
    input  pll_locked,
    input  restart,
    input  clr_status,
    output pll_rst,
    output audio_rst_n,
    output ready,
    output fail,
    output lock_lost,
    output retry_count,
    output state_o
  );

  modport slave (
    output pll_locked,
    output restart,
    output clr_status,
    input  pll_rst,
    input  audio_rst_n,
    input  ready,
    input  fail,
    input  lock_lost,
    input  retry_count,
    input  state_o
  );
endinterface

// File: rtl/audio_pll_lock_ctrl.sv
// Audio PLL reset/lock sequencer: pulses PLL reset, qualifies lock, retries.
// Ports: refclk, rst_n (async low), bus (master modport of the bundle).
module audio_pll_lock_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input logic                    refclk,
  input logic                    rst_n,
  audio_pll_lock_ctrl_if.master  bus
);

  localparam int unsigned M1 =
    (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
    RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MC =
    (M1 > LOCK_STABLE_CYCLES) ? M1 : LOCK_STABLE_CYCLES;
  localparam int unsigned CW = $clog2(MC);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          lost_q, lost_d;
  logic          sync1_q, sync2_q;
  logic          pll_rst_q, arst_n_q, ready_q, fail_q;
  logic          locked_s;
  logic          lost_set;

  assign locked_s = sync2_q;
  assign lost_set = (state_q == RUN) && !locked_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    unique case (state_q)
      RESET_PLL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        cnt_d = cnt_q + CW'(1);
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = FAIL;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = RESET_PLL;
          end
        end
      end
      STABLE: begin
        cnt_d = cnt_q + CW'(1);
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == ST_LAST) begin
          state_d = RUN;
          retry_d = '0;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
      end
      FAIL: ;
      default: state_d = RESET_PLL;
    endcase
    if (bus.restart) begin
      state_d = RESET_PLL;
      retry_d = '0;
    end
    // Every state change (and a restart in place) starts the count over.
    if (state_d != state_q || bus.restart) cnt_d = '0;
    // A new loss event beats a clear in the same cycle.
    lost_d = lost_set | (lost_q & ~bus.clr_status);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      lost_q    <= 1'b0;
      pll_rst_q <= 1'b1;
      arst_n_q  <= 1'b0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      sync1_q   <= bus.pll_locked;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_rst_q <= (state_d == RESET_PLL) || (state_d == FAIL);
      arst_n_q  <= (state_d == RUN);
      ready_q   <= (state_d == RUN);
      fail_q    <= (state_d == FAIL);
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.audio_rst_n = arst_n_q;
  assign bus.ready       = ready_q;
  assign bus.fail        = fail_q;
  assign bus.lock_lost   = lost_q;
  assign bus.retry_count = retry_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_audio_pll_lock_ctrl.sv
// Directed scoreboard bench for audio_pll_lock_ctrl.
// Short parameters: 4-cycle pulse, 20 timeout, 8 stable, 2 retries.
module tb_audio_pll_lock_ctrl;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;

  always #5 refclk = ~refclk;

  audio_pll_lock_ctrl_if bus ();

  audio_pll_lock_ctrl #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .MAX_RETRIES         (2)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // {pll_rst, audio_rst_n, ready, fail, lock_lost, retry[3:0], state[2:0]}
  function automatic logic [11:0] v(
    input logic p, input logic a, input logic r,
    input logic f, input logic l,
    input logic [3:0] rc, input logic [2:0] s
  );
    return {p, a, r, f, l, rc, s};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic push(input string t, input logic [11:0] e);
    exp_t x;
    x.tag = t;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [11:0] obs;
    obs = {bus.pll_rst, bus.audio_rst_n, bus.ready, bus.fail,
           bus.lock_lost, bus.retry_count, bus.state_o};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input string t, input int n,
                      input logic [11:0] e);
    push(t, e);
    tick(n);
    pop_check();
  endtask

  initial begin
    bus.pll_locked = 1'b1;
    bus.restart    = 1'b0;
    bus.clr_status = 1'b0;
    tick(2);
    step("reset", 0, v(1,0,0,0,0,4'd0,3'd0));

    // Clean lock with pll_locked held high.
    rst_n = 1'b1;
    step("t1_e3_rst",   3, v(1,0,0,0,0,4'd0,3'd0));
    step("t1_e4_wait",  1, v(0,0,0,0,0,4'd0,3'd1));
    step("t1_e5_stab",  1, v(0,0,0,0,0,4'd0,3'd2));
    step("t1_e12_stab", 7, v(0,0,0,0,0,4'd0,3'd2));
    step("t1_e13_run",  1, v(0,1,1,0,0,4'd0,3'd3));

    // Lock drop in RUN, sticky lock_lost through relock, then clear.
    bus.pll_locked = 1'b0;
    step("t3_loss",     3, v(1,0,0,0,1,4'd0,3'd0));
    tick(2);
    bus.pll_locked = 1'b1;
    step("t3_relock_st", 10, v(0,0,0,0,1,4'd0,3'd2));
    step("t3_relock_run", 1, v(0,1,1,0,1,4'd0,3'd3));
    bus.clr_status = 1'b1;
    push("t3_clr", v(0,1,1,0,0,4'd0,3'd3));
    tick(1);
    bus.clr_status = 1'b0;
    pop_check();

    // Short lock drop at stable count 5 sends STABLE back to WAIT_LOCK.
    bus.restart = 1'b1;
    push("t4_restart", v(1,0,0,0,0,4'd0,3'd0));
    tick(1);
    bus.restart = 1'b0;
    pop_check();
    step("t4_in_stab", 8, v(0,0,0,0,0,4'd0,3'd2));
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    step("t4_back_wait", 2, v(0,0,0,0,0,4'd0,3'd1));
    step("t4_restab",    1, v(0,0,0,0,0,4'd0,3'd2));
    step("t4_no_ready",  7, v(0,0,0,0,0,4'd0,3'd2));
    step("t4_run",       1, v(0,1,1,0,0,4'd0,3'd3));

    // Restart coinciding with loss: lock_lost still sets.
    bus.pll_locked = 1'b0;
    tick(2);
    bus.restart = 1'b1;
    push("t5_rst_loss", v(1,0,0,0,1,4'd0,3'd0));
    tick(1);
    bus.restart = 1'b0;
    pop_check();
    bus.pll_locked = 1'b1;
    step("t5_run", 13, v(0,1,1,0,1,4'd0,3'd3));
    bus.clr_status = 1'b1;
    push("t5_clr", v(0,1,1,0,0,4'd0,3'd3));
    tick(1);
    bus.clr_status = 1'b0;
    pop_check();
    bus.pll_locked = 1'b0;
    step("t5_pre_loss", 2, v(0,1,1,0,0,4'd0,3'd3));
    bus.clr_status = 1'b1;
    push("t5_set_wins", v(1,0,0,0,1,4'd0,3'd0));
    tick(1);
    bus.clr_status = 1'b0;
    pop_check();

    // No lock at all: three attempts then FAIL.
    step("t2_wait0",  4,  v(0,0,0,0,1,4'd0,3'd1));
    step("t2_wait0e", 19, v(0,0,0,0,1,4'd0,3'd1));
    step("t2_retry1", 1,  v(1,0,0,0,1,4'd1,3'd0));
    step("t2_retry2", 24, v(1,0,0,0,1,4'd2,3'd0));
    step("t2_fail",   24, v(1,0,0,1,1,4'd2,3'd4));
    step("t2_hold",   5,  v(1,0,0,1,1,4'd2,3'd4));
    bus.restart = 1'b1;
    push("t2_restart", v(1,0,0,0,1,4'd0,3'd0));
    tick(1);
    bus.restart = 1'b0;
    pop_check();

    // Asynchronous reset in the middle of STABLE.
    bus.pll_locked = 1'b1;
    step("t6_stab", 7, v(0,0,0,0,1,4'd0,3'd2));
    #2;
    rst_n = 1'b0;
    push("t6_async", v(1,0,0,0,0,4'd0,3'd0));
    #1;
    pop_check();
    tick(2);
    rst_n = 1'b1;
    step("t6_after", 2, v(1,0,0,0,0,4'd0,3'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_pll_lock_ctrl.md
Name: audio_pll_lock_ctrl

Overview:
- Reset/lock sequencer for the audio PLL, which produces the 18.432 MHz audio clock from the 50 MHz reference.
- Drives the PLL's active-high reset and monitors its asynchronous `locked` output.
- Qualifies lock as stable before releasing the audio-domain reset, and retries a bounded number of times on lock timeout.
- Runs entirely in the reference-clock domain; sits between board reset and the PLL/audio codec logic.

Parameters:
- RST_PULSE_CYCLES, 16: cycles `pll_rst` is held high per reset attempt (≥2).
- LOCK_TIMEOUT_CYCLES, 50000: cycles to wait for lock after `pll_rst` release (1 ms at 50 MHz).
- LOCK_STABLE_CYCLES, 1024: consecutive locked cycles required before release.
- MAX_RETRIES, 3: retries after the first attempt before declaring failure (0..15).

Ports:
- refclk  in  1  50 MHz reference clock; the single clock of the block.
- rst_n  in  1  reset; asynchronous assert, active-low.
- pll_locked  in  1  PLL `locked`; asynchronous to `refclk`.
- restart  in  1  sync single-cycle request to restart the sequence from scratch.
- clr_status  in  1  sync single-cycle clear of `lock_lost`.
- pll_rst  out  1  active-high PLL reset.
- audio_rst_n  out  1  active-low reset for audio-clock-domain logic; high only in RUN.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- lock_lost  out  1  sticky: lock dropped while in RUN.
- retry_count  out  4  timeouts in the current sequence.
- state_o  out  3  current state: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0) values:
  - state=RESET_PLL, counter=0, retry_count=0, synchronizer flops=0.
  - pll_rst=1, audio_rst_n=0, ready=0, fail=0, lock_lost=0.
- Lock synchronizer: `pll_locked` passes through a 2-flop synchronizer; `locked_s` is its output. Only `locked_s` is used internally.
- Output timing: all outputs are registered and updated on the same edge as the state register. No extra latency.
- One shared counter; it clears on every state change.
- State machine:
  - RESET_PLL: pll_rst=1. Counter increments each cycle. On the edge where counter==RST_PULSE_CYCLES-1, go to WAIT_LOCK. `pll_rst` is therefore high for exactly RST_PULSE_CYCLES cycles after reset.
  - WAIT_LOCK: pll_rst=0.
    - If locked_s=1, go to STABLE.
    - Otherwise, on the edge where counter==LOCK_TIMEOUT_CYCLES-1 (timeout):
      - if retry_count==MAX_RETRIES, go to FAIL;
      - else retry_count+1 and go to RESET_PLL.
  - STABLE: pll_rst=0.
    - If locked_s=0 at any cycle, go to WAIT_LOCK; the timeout restarts from 0 and retry_count is unchanged.
    - On the edge where counter==LOCK_STABLE_CYCLES-1 with locked_s=1, go to RUN and clear retry_count.
  - RUN: audio_rst_n=1, ready=1. If locked_s=0, set lock_lost, go to RESET_PLL, and clear retry_count. audio_rst_n falls on that same edge.
  - FAIL: pll_rst=1, fail=1. Holds until `restart` or rst_n.
- `restart` (any state):
  - Next state is RESET_PLL with counter=0 and retry_count=0; fail clears on the same edge.
  - Has priority over every other transition.
  - Asserted while already in RESET_PLL, it restarts the pulse count.
- `lock_lost` simultaneous events:
  - The lock_lost set condition is evaluated even when `restart` wins the transition.
  - If set and `clr_status` occur in the same cycle, set wins.
- Counter width is $clog2 of the largest of the three cycle parameters. No wrap-around is reachable, because every count terminates on an equality compare.
- `pll_locked` glitches shorter than one `refclk` period may be missed. This is acceptable.

Test Plan:
(Use parameters RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.)
1. Release rst_n with pll_locked=1 constant -> pll_rst high for 4 edges, falls at edge 4; ready and audio_rst_n rise at edge 13; retry_count=0; state_o=3.
2. pll_locked=0 forever -> three attempts, each 4 cycles RESET_PLL plus 20 cycles WAIT_LOCK; retry_count steps 1, 2; then fail=1, pll_rst=1, state_o=4, retry_count=2. Pulse restart -> fail=0 next edge, retry_count=0, state_o=0.
3. Lock once in RUN, then drop pll_locked for 5 cycles -> 2-3 edges later lock_lost=1, audio_rst_n=0, ready=0, state_o=0. It stays set through the relock. clr_status clears it.
4. During STABLE, drop pll_locked at stable count 5 -> state returns to WAIT_LOCK; ready is not asserted until 8 further consecutive locked cycles.
5. Assert restart in the same cycle locked_s falls in RUN -> state_o=0, and lock_lost=1 still set. clr_status together with a lock-loss event -> lock_lost stays 1.
6. Assert rst_n low mid-STABLE, asynchronous to refclk -> all outputs return to reset values immediately, without waiting for a clock edge.
